// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory request outstanding and buffers the
// returned words for decode. Define FETCH_STATS_EN to add fetched/discarded word counters.
module fetch_unit #(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned          DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                inst_ready,
  output logic                inst_valid,
  output logic [31:0]         inst,
  output logic [PC_WIDTH-1:0] inst_pc,
  output logic [6:0]          opcode,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]         stat_fetched,
  output logic [31:0]         stat_discarded
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

  state_e              state_q;
  logic                req_q;
  logic [PC_WIDTH-1:0] fetch_pc_q;
  logic [PC_WIDTH-1:0] req_addr_q;
  logic [CntW-1:0]     count_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [PtrW-1:0]     wr_ptr_q;
  logic [31:0]         buf_inst_q [DEPTH];
  logic [PC_WIDTH-1:0] buf_pc_q   [DEPTH];

  logic                pop;
  logic                push;
  logic                can_issue;
  logic                room_after_push;
  logic [CntW-1:0]     count_after_push;
  logic [PC_WIDTH-1:0] req_addr_inc;

  assign inst_valid       = (count_q != '0);
  assign pop              = inst_valid && inst_ready && !redirect_valid;
  assign push             = (state_q == StReq) && imem_ack && !redirect_valid;
  assign count_after_push = count_q - CntW'(pop) + CntW'(push);
  assign can_issue        = count_q < CntW'(DEPTH);
  assign room_after_push  = count_after_push < CntW'(DEPTH);
  assign req_addr_inc     = req_addr_q + PC_WIDTH'(4);

  assign imem_req  = req_q;
  assign imem_addr = req_addr_q;

  assign inst    = inst_valid ? buf_inst_q[rd_ptr_q] : Nop;
  assign inst_pc = inst_valid ? buf_pc_q[rd_ptr_q] : '0;
  assign opcode  = inst[6:0];
  assign funct3  = inst[14:12];
  assign funct7  = inst[31:25];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      // A redirect flushes the buffer and overrides any same-cycle push or pop.
      if (redirect_valid) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q <= count_after_push;
      end

      case (state_q)
        StIdle: begin
          if (redirect_valid) begin
            fetch_pc_q <= redirect_pc;
          end else if (can_issue) begin
            req_addr_q <= fetch_pc_q;
            state_q    <= StReq;
            req_q      <= 1'b1;
          end
        end
        StReq: begin
          if (redirect_valid) begin
            fetch_pc_q <= redirect_pc;
            if (imem_ack) begin
              req_addr_q <= redirect_pc;
            end else begin
              // Request must stay up until memory answers; its data is then dropped.
              state_q <= StDiscard;
            end
          end else if (imem_ack) begin
            fetch_pc_q <= req_addr_inc;
            if (room_after_push) begin
              req_addr_q <= req_addr_inc;
            end else begin
              state_q <= StIdle;
              req_q   <= 1'b0;
            end
          end
        end
        StDiscard: begin
          if (redirect_valid) fetch_pc_q <= redirect_pc;
          if (imem_ack) begin
            req_addr_q <= redirect_valid ? redirect_pc : fetch_pc_q;
            state_q    <= StReq;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]   <= req_addr_q;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q;
  logic [31:0] stat_discarded_q;
  logic        drop_word;
  logic [32:0] fetched_sum;
  logic [32:0] discarded_sum;

  assign drop_word = imem_ack &&
                     ((state_q == StDiscard) || ((state_q == StReq) && redirect_valid));
  assign fetched_sum   = {1'b0, stat_fetched_q} + 33'(push);
  assign discarded_sum = {1'b0, stat_discarded_q} + 33'(drop_word) +
                         33'(redirect_valid ? count_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched_q   <= '0;
      stat_discarded_q <= '0;
    end else begin
      stat_fetched_q   <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
      stat_discarded_q <= discarded_sum[32] ? 32'hFFFF_FFFF : discarded_sum[31:0];
    end
  end

  assign stat_fetched   = stat_fetched_q;
  assign stat_discarded = stat_discarded_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table driving memory, redirect and decode
// handshakes, followed by a hand-written redirect-in-IDLE / redirect-in-DISCARD sequence.
module tb_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_discarded;
`endif

  fetch_unit #(
    .PC_WIDTH (32),
    .RESET_PC (32'h0),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_ready     (inst_ready),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_discarded (stat_discarded)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        ack;
    logic [31:0] rdata;
    logic        rv;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [30];

  // Memory contents: a distinct, address-derived word so every field slice is exercised.
  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic vec_t mk(input logic r, input logic ack, input logic [31:0] rdata,
                              input logic rv, input logic [31:0] rpc, input logic ready,
                              input logic ereq, input logic [31:0] eaddr, input logic evalid,
                              input logic [31:0] epc);
    vec_t v;
    v.rst_n     = r;
    v.ack       = ack;
    v.rdata     = rdata;
    v.rv        = rv;
    v.rpc       = rpc;
    v.ready     = ready;
    v.exp_req   = ereq;
    v.exp_addr  = eaddr;
    v.exp_valid = evalid;
    v.exp_pc    = evalid ? epc : 32'h0;
    v.exp_inst  = evalid ? w(epc) : Nop;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic rv,
                       input logic [31:0] rpc, input logic ready);
    @(negedge clk);
    imem_ack       = ack;
    imem_rdata     = rdata;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = ready;
    #1;
  endtask

  initial begin
    logic [31:0] ei;
    rst_n          = 1'b0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;

    //            rst ack rdata               rv rpc            rdy  req addr          vld pc
    vecs[0]  = mk(0, 0, 0,                    0, 0,             0,   0, 32'h0,         0, 0);
    vecs[1]  = mk(1, 0, 0,                    0, 0,             1,   0, 32'h0,         0, 0);
    vecs[2]  = mk(1, 1, w(32'h0),             0, 0,             1,   1, 32'h0,         0, 0);
    vecs[3]  = mk(1, 1, w(32'h4),             0, 0,             1,   1, 32'h4,         1, 32'h0);
    vecs[4]  = mk(1, 1, w(32'h8),             0, 0,             1,   1, 32'h8,         1, 32'h4);
    vecs[5]  = mk(1, 1, w(32'hC),             0, 0,             0,   1, 32'hC,         1, 32'h8);
    vecs[6]  = mk(1, 0, 0,                    0, 0,             0,   0, 32'hC,         1, 32'h8);
    vecs[7]  = mk(1, 0, 0,                    0, 0,             0,   0, 32'hC,         1, 32'h8);
    vecs[8]  = mk(1, 0, 0,                    0, 0,             1,   0, 32'hC,         1, 32'h8);
    vecs[9]  = mk(1, 0, 0,                    0, 0,             0,   0, 32'hC,         1, 32'hC);
    vecs[10] = mk(1, 0, 0,                    0, 0,             0,   1, 32'h10,        1, 32'hC);
    vecs[11] = mk(1, 0, 0,                    1, 32'h100,       0,   1, 32'h10,        1, 32'hC);
    vecs[12] = mk(1, 0, 0,                    0, 0,             0,   1, 32'h10,        0, 0);
    vecs[13] = mk(1, 1, w(32'h10),            0, 0,             1,   1, 32'h10,        0, 0);
    vecs[14] = mk(1, 0, 0,                    0, 0,             1,   1, 32'h100,       0, 0);
    vecs[15] = mk(1, 1, w(32'h100),           0, 0,             0,   1, 32'h100,       0, 0);
    vecs[16] = mk(1, 1, w(32'h104),           0, 0,             0,   1, 32'h104,       1, 32'h100);
    vecs[17] = mk(1, 0, 0,                    0, 0,             1,   0, 32'h104,       1, 32'h100);
    vecs[18] = mk(1, 0, 0,                    0, 0,             0,   0, 32'h104,       1, 32'h104);
    vecs[19] = mk(1, 1, w(32'h108),           1, 32'h200,       1,   1, 32'h108,       1, 32'h104);
    vecs[20] = mk(1, 0, 0,                    0, 0,             1,   1, 32'h200,       0, 0);
    vecs[21] = mk(1, 1, w(32'h200),           0, 0,             1,   1, 32'h200,       0, 0);
    vecs[22] = mk(1, 0, 0,                    0, 0,             0,   1, 32'h204,       1, 32'h200);
    vecs[23] = mk(1, 0, 0,                    1, 32'hFFFF_FFFC, 0,   1, 32'h204,       1, 32'h200);
    vecs[24] = mk(1, 1, w(32'h204),           0, 0,             1,   1, 32'h204,       0, 0);
    vecs[25] = mk(1, 1, w(32'hFFFF_FFFC),     0, 0,             0,   1, 32'hFFFF_FFFC, 0, 0);
    vecs[26] = mk(1, 0, 0,                    0, 0,             0,   1, 32'h0,         1, 32'hFFFF_FFFC);
    vecs[27] = mk(0, 0, 0,                    0, 0,             0,   0, 32'h0,         0, 0);
    vecs[28] = mk(1, 0, 0,                    0, 0,             0,   0, 32'h0,         0, 0);
    vecs[29] = mk(1, 0, 0,                    0, 0,             0,   1, 32'h0,         0, 0);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rst_n          = vecs[i].rst_n;
      imem_ack       = vecs[i].ack;
      imem_rdata     = vecs[i].rdata;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      inst_ready     = vecs[i].ready;
      #1;
      ei = vecs[i].exp_inst;
      chk("imem_req",   i, 32'(imem_req),   32'(vecs[i].exp_req));
      chk("imem_addr",  i, imem_addr,       vecs[i].exp_addr);
      chk("inst_valid", i, 32'(inst_valid), 32'(vecs[i].exp_valid));
      chk("inst_pc",    i, inst_pc,         vecs[i].exp_pc);
      chk("inst",       i, inst,            ei);
      chk("opcode",     i, 32'(opcode),     32'(ei[6:0]));
      chk("funct3",     i, 32'(funct3),     32'(ei[14:12]));
      chk("funct7",     i, 32'(funct7),     32'(ei[31:25]));
    end

    // Fill the buffer, redirect while idle, then redirect twice while a request is in flight.
    drive(1, w(32'h0), 0, 0, 0);
    drive(1, w(32'h4), 0, 0, 0);
    chk("seq_addr", 0, imem_addr, 32'h4);
    chk("seq_pc",   0, inst_pc,   32'h0);
    drive(0, 0, 1, 32'h300, 0);
    chk("seq_req_idle_full", 1, 32'(imem_req), 32'd0);
    chk("seq_valid_full",    1, 32'(inst_valid), 32'd1);
    drive(0, 0, 0, 0, 0);
    chk("seq_req_after_flush", 2, 32'(imem_req), 32'd0);
    chk("seq_valid_flushed",   2, 32'(inst_valid), 32'd0);
    chk("seq_inst_nop",        2, inst, Nop);
    drive(0, 0, 1, 32'h400, 0);
    chk("seq_req_redirected", 3, 32'(imem_req), 32'd1);
    chk("seq_addr_redirected", 3, imem_addr, 32'h300);
    drive(0, 0, 1, 32'h500, 0);
    chk("seq_req_held",  4, 32'(imem_req), 32'd1);
    chk("seq_addr_held", 4, imem_addr, 32'h300);
    drive(1, w(32'h300), 0, 0, 1);
    chk("seq_addr_discard", 5, imem_addr, 32'h300);
    chk("seq_valid_discard", 5, 32'(inst_valid), 32'd0);
    drive(1, w(32'h500), 0, 0, 1);
    chk("seq_addr_last_redirect", 6, imem_addr, 32'h500);
    chk("seq_valid_before_push",  6, 32'(inst_valid), 32'd0);
    drive(0, 0, 0, 0, 1);
    chk("seq_valid_pushed", 7, 32'(inst_valid), 32'd1);
    chk("seq_pc_pushed",    7, inst_pc, 32'h500);
    chk("seq_inst_pushed",  7, inst, w(32'h500));
    chk("seq_addr_next",    7, imem_addr, 32'h504);
    drive(0, 0, 0, 0, 1);
    chk("seq_valid_popped", 8, 32'(inst_valid), 32'd0);
    drive(0, 0, 0, 0, 1);
    chk("seq_ready_on_empty", 9, 32'(inst_valid), 32'd0);
    chk("seq_pc_empty",       9, inst_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
